bf_run_ctrl: RTL and testbench
==============================

# bf_run_ctrl

Run controller for the bf core. It loads a program into program RAM from a host nibble stream and zero-fills data RAM. It then runs the core under a clock enable until the end opcode (0xF) or a host stop. While running, it buffers the core's `print` characters in a FIFO toward the terminal and stalls the core when the FIFO is nearly full. It owns the address/write ports of both RAMs and multiplexes them between the host, the clear sweep and the core.

## Interface
- `PRG_AW`, 16, program RAM address width (4-bit words)
- `DAT_AW`, 16, data RAM address width (8-bit words)
- `FIFO_DEPTH`, 8, print FIFO entries (power of two, ≥4)
- `clock`  in  1  single clock; all logic on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_load`, `cmd_run`, `cmd_stop`  in  1 each  host command pulses
- `load_valid`  in  1  host nibble valid
- `load_nib`  in  4  program opcode
- `load_last`  in  1  marks the final nibble
- `load_ready`  out  1  nibble accepted when `load_valid && load_ready`
- `prg_addr`  out  PRG_AW  program RAM address
- `prg_wdata`  out  4  program RAM write data
- `prg_we`  out  1  program RAM write strobe
- `prg_rdata`  in  4  program RAM read data, asynchronous read of `prg_addr`
- `dat_addr`  out  DAT_AW  data RAM address
- `dat_wdata`  out  8  data RAM write data
- `dat_we`  out  1  data RAM write strobe
- `core_pc`  in  16  core program counter
- `core_cursor`  in  16  core data pointer
- `core_out`  in  8  core write/print data
- `core_we`  in  1  core write request
- `core_print`  in  1  core print request
- `core_ce`  out  1  core clock enable; core registers update only when high
- `core_rst`  out  1  one-cycle synchronous core reset (pc, cursor, tstate to 0)
- `tx_data`  out  8  FIFO head character
- `tx_valid`  out  1  FIFO head valid
- `tx_ready`  in  1  head consumed when `tx_valid && tx_ready`
- `busy`  out  1  high when state ∉ {IDLE, DONE}
- `halted`  out  1  high in DONE
- `run_cycles`  out  32  enabled core cycles of the last run

## Operation
- States: IDLE, LOAD, CLEAR, RUN, DRAIN, DONE. Reset enters IDLE.
- Command priority when pulses coincide: stop > load > run. Commands not listed for a state are ignored.
- IDLE or DONE:
  - `cmd_load` → LOAD; the load pointer is set to 0.
  - `cmd_run` → CLEAR; the clear pointer and `run_cycles` are set to 0.
- LOAD:
  - `load_ready` = 1.
  - Each accepted nibble drives `prg_we` = 1, `prg_addr` = pointer, `prg_wdata` = `load_nib`, then the pointer increments and wraps modulo 2^PRG_AW.
  - An accepted nibble with `load_last` = 1 → IDLE.
  - `cmd_stop` → IDLE, and any nibble offered that cycle is not written.
- CLEAR:
  - Each cycle drives `dat_we` = 1, `dat_wdata` = 0, `dat_addr` = pointer.
  - After the write to address 2^DAT_AW−1 → RUN, with `core_rst` asserted on that transition cycle.
  - `cmd_stop` → IDLE.
- RUN:
  - `prg_addr` = `core_pc[PRG_AW-1:0]`, `dat_addr` = `core_cursor[DAT_AW-1:0]`.
  - `core_ce` = 1 iff free FIFO slots ≥ 2 and not the `core_rst` cycle.
  - `ce_q` is `core_ce` registered by one cycle. `dat_we` = `core_we && ce_q`, `dat_wdata` = `core_out`.
  - Push = `core_print && ce_q`, writing `core_out`. The push always finds space because of the 2-slot headroom.
  - `prg_rdata` = 0xF while `core_ce` = 1 → DRAIN; that cycle's core update is still enabled.
  - `cmd_stop` → DRAIN.
- DRAIN: `core_ce` = 0. A pending print (`ce_q` = 1) is still pushed. FIFO empty → DONE.
- DONE: `halted` = 1. Core and RAM contents are left untouched for host inspection.
- `run_cycles` increments on every `core_ce` = 1 cycle and saturates at 0xFFFF_FFFF.
- FIFO: `tx_valid` = not empty. A push and a pop in the same cycle are both performed and leave the count unchanged. The FIFO also drains in IDLE and DONE.

## Timing
- Reset values:
  - `load_ready`, `prg_we`, `dat_we`, `core_ce`, `core_rst`, `tx_valid`, `busy`, `halted` = 0.
  - Addresses, write data, `tx_data` and `run_cycles` = 0.
  - FIFO empty, `ce_q` = 0.
- Reset asserted mid-operation aborts immediately: no RAM write after the asserting edge, FIFO is flushed.
- `load_ready`, `prg_we` and `dat_we` are combinational from state and inputs. `core_ce` is combinational from state and the FIFO count. `tx_data` comes from a registered FIFO.
- CLEAR lasts exactly 2^DAT_AW cycles. `core_ce` first rises on the cycle after `core_rst`.
- `cmd_run` to first enabled core cycle = 2^DAT_AW + 2 cycles.
- A print pushed at edge N is visible on `tx_valid` at N+1.

## Test plan
- Load "++.", then 0xF (4 nibbles), `cmd_run`, `tx_ready` = 1 → exactly one `tx_data` = 0x02 character; DONE reached; `run_cycles` = 4.
- Load "+[.]" with `tx_ready` held 0 → `core_ce` drops when 7 entries are present (FIFO_DEPTH 8) and no character is lost or duplicated. Then `tx_ready` = 1 with `cmd_stop` → all buffered 0x01 characters delivered, then DONE.
- `cmd_stop`, `cmd_load` and `cmd_run` in the same cycle during IDLE → stays IDLE. `cmd_load` with `cmd_run` → LOAD.
- DAT_AW = 4, pre-fill data RAM with 0xAA, `cmd_run` → 16 zero writes to addresses 0..15, then one `core_rst` pulse.
- Assert `reset_n` = 0 mid-CLEAR and mid-RUN with a non-empty FIFO → all outputs at reset values next sample, `tx_valid` = 0, `dat_we` = 0.
- PRG_AW = 4, load 17 nibbles → the 17th overwrites address 0; `load_last` on the 17th nibble → IDLE.

Source files
------------

// File: rtl/bf_run_ctrl.sv
// bf core run controller: program load, data RAM clear, gated run
// and print FIFO toward the terminal.
`timescale 1ns/1ps
module bf_run_ctrl #(
    parameter int PRG_AW     = 16,
    parameter int DAT_AW     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_load,
    input  logic              cmd_run,
    input  logic              cmd_stop,
    input  logic              load_valid,
    input  logic [3:0]        load_nib,
    input  logic              load_last,
    output logic              load_ready,
    output logic [PRG_AW-1:0] prg_addr,
    output logic [3:0]        prg_wdata,
    output logic              prg_we,
    input  logic [3:0]        prg_rdata,
    output logic [DAT_AW-1:0] dat_addr,
    output logic [7:0]        dat_wdata,
    output logic              dat_we,
    input  logic [15:0]       core_pc,
    input  logic [15:0]       core_cursor,
    input  logic [7:0]        core_out,
    input  logic              core_we,
    input  logic              core_print,
    output logic              core_ce,
    output logic              core_rst,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              halted,
    output logic [31:0]       run_cycles
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [FAW:0] CNT_HI = (FAW+1)'(FIFO_DEPTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [PRG_AW-1:0] ld_ptr;
    logic [DAT_AW-1:0] clr_ptr;
    logic              rst_q;
    logic              ce_q;
    logic              ce;
    logic              push;
    logic              pop;

    logic [7:0] mem [FIFO_DEPTH];
    logic [FAW-1:0] rd_ptr;
    logic [FAW-1:0] wr_ptr;
    logic [FAW:0]   count;

    logic unused_bits;
    assign unused_bits = ^{core_pc, core_cursor};

    always_comb begin
        state_nx   = state;
        load_ready = 1'b0;
        prg_addr   = '0;
        prg_wdata  = '0;
        prg_we     = 1'b0;
        dat_addr   = '0;
        dat_wdata  = '0;
        dat_we     = 1'b0;
        ce         = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (!cmd_stop && cmd_load)
                    state_nx = S_LOAD;
                else if (!cmd_stop && cmd_run)
                    state_nx = S_CLEAR;
            end
            S_LOAD: begin
                load_ready = !cmd_stop;
                prg_addr   = ld_ptr;
                prg_wdata  = load_nib;
                prg_we     = load_valid && !cmd_stop;
                if (cmd_stop)
                    state_nx = S_IDLE;
                else if (load_valid && load_last)
                    state_nx = S_IDLE;
            end
            S_CLEAR: begin
                dat_we   = 1'b1;
                dat_addr = clr_ptr;
                if (cmd_stop)
                    state_nx = S_IDLE;
                else if (&clr_ptr)
                    state_nx = S_RUN;
            end
            S_RUN, S_DRAIN: begin
                prg_addr  = core_pc[PRG_AW-1:0];
                dat_addr  = core_cursor[DAT_AW-1:0];
                dat_wdata = core_out;
                dat_we    = core_we && ce_q;
                if (state == S_RUN) begin
                    // two free slots cover the print still in flight
                    ce = (count <= CNT_HI) && !rst_q;
                    if (cmd_stop)
                        state_nx = S_DRAIN;
                    else if (ce && prg_rdata == 4'hF)
                        state_nx = S_DRAIN;
                end else if (count == '0 && !push) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign push = core_print && ce_q;
    assign pop  = (count != '0) && tx_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ld_ptr     <= '0;
            clr_ptr    <= '0;
            rst_q      <= 1'b0;
            ce_q       <= 1'b0;
            run_cycles <= '0;
        end else begin
            state <= state_nx;
            rst_q <= (state == S_CLEAR) && (state_nx == S_RUN);
            ce_q  <= ce;
            if (state != S_LOAD && state_nx == S_LOAD)
                ld_ptr <= '0;
            else if (prg_we)
                ld_ptr <= ld_ptr + PRG_AW'(1);
            if (state != S_CLEAR)
                clr_ptr <= '0;
            else
                clr_ptr <= clr_ptr + DAT_AW'(1);
            if (state != S_CLEAR && state_nx == S_CLEAR)
                run_cycles <= '0;
            else if (ce && run_cycles != '1)
                run_cycles <= run_cycles + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= core_out;
                wr_ptr      <= wr_ptr + FAW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + FAW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (FAW+1)'(1);
                2'b01:   count <= count - (FAW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign tx_data  = mem[rd_ptr];
    assign tx_valid = (count != '0);
    assign core_ce  = ce;
    assign core_rst = rst_q;
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign halted   = (state == S_DONE);

endmodule

// File: tb/tb_bf_run_ctrl.sv
// Directed bench for bf_run_ctrl with a small behavioural bf core
// and RAM models; opcodes 1 '+', 2 '-', 5 '[', 6 ']', 7 '.', F end.
`timescale 1ns/1ps
module tb_bf_run_ctrl;

    localparam int PAW = 4;
    localparam int DAW = 4;
    localparam int FD  = 8;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           cmd_load = 1'b0;
    logic           cmd_run = 1'b0;
    logic           cmd_stop = 1'b0;
    logic           load_valid = 1'b0;
    logic [3:0]     load_nib = 4'h0;
    logic           load_last = 1'b0;
    logic           load_ready;
    logic [PAW-1:0] prg_addr;
    logic [3:0]     prg_wdata;
    logic           prg_we;
    logic [3:0]     prg_rdata;
    logic [DAW-1:0] dat_addr;
    logic [7:0]     dat_wdata;
    logic           dat_we;
    logic [15:0]    core_pc = 16'h0;
    logic [15:0]    core_cursor = 16'h0;
    logic [7:0]     core_out = 8'h0;
    logic           core_we = 1'b0;
    logic           core_print = 1'b0;
    logic           core_ce;
    logic           core_rst;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b0;
    logic           busy;
    logic           halted;
    logic [31:0]    run_cycles;

    logic [3:0] prg_ram [16] = '{default: 4'h0};
    logic [7:0] dat_ram [16] = '{default: 8'hAA};
    logic [3:0] prog [$];
    logic [7:0] rx [$];
    int n_print = 0;
    int total = 0;
    int bad = 0;
    logic [7:0] cur;
    logic [67:0] outs;

    bf_run_ctrl #(
        .PRG_AW(PAW),
        .DAT_AW(DAW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cmd_load(cmd_load),
        .cmd_run(cmd_run),
        .cmd_stop(cmd_stop),
        .load_valid(load_valid),
        .load_nib(load_nib),
        .load_last(load_last),
        .load_ready(load_ready),
        .prg_addr(prg_addr),
        .prg_wdata(prg_wdata),
        .prg_we(prg_we),
        .prg_rdata(prg_rdata),
        .dat_addr(dat_addr),
        .dat_wdata(dat_wdata),
        .dat_we(dat_we),
        .core_pc(core_pc),
        .core_cursor(core_cursor),
        .core_out(core_out),
        .core_we(core_we),
        .core_print(core_print),
        .core_ce(core_ce),
        .core_rst(core_rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .halted(halted),
        .run_cycles(run_cycles)
    );

    always #5 clock = ~clock;

    assign outs = {load_ready, prg_addr, prg_wdata, prg_we,
                   dat_addr, dat_wdata, dat_we, core_ce, core_rst,
                   tx_data, tx_valid, busy, halted, run_cycles};

    assign prg_rdata = prg_ram[prg_addr];
    assign cur = (dat_we && dat_addr == core_cursor[DAW-1:0])
               ? dat_wdata : dat_ram[core_cursor[DAW-1:0]];

    always @(posedge clock) begin
        if (prg_we) prg_ram[prg_addr] <= prg_wdata;
        if (dat_we) dat_ram[dat_addr] <= dat_wdata;
    end

    function automatic logic [15:0] seek(input logic [15:0] p,
                                         input bit fwd);
        int d = 0;
        logic [15:0] q = p;
        for (int k = 0; k < 16; k++) begin
            q = fwd ? q + 16'd1 : q - 16'd1;
            if (prg_ram[q[3:0]] == (fwd ? 4'h5 : 4'h6)) begin
                d++;
            end else if (prg_ram[q[3:0]] == (fwd ? 4'h6 : 4'h5)) begin
                if (d == 0) return q;
                d--;
            end
        end
        return q;
    endfunction

    always @(posedge clock) begin
        if (core_rst) begin
            core_pc     <= 16'h0;
            core_cursor <= 16'h0;
            core_we     <= 1'b0;
            core_print  <= 1'b0;
        end else if (core_ce) begin
            core_we    <= 1'b0;
            core_print <= 1'b0;
            core_pc    <= core_pc + 16'd1;
            case (prg_rdata)
                4'h1: begin core_out <= cur + 8'd1; core_we <= 1'b1; end
                4'h2: begin core_out <= cur - 8'd1; core_we <= 1'b1; end
                4'h5: if (cur == 8'h0) core_pc <= seek(core_pc, 1'b1) + 16'd1;
                4'h6: if (cur != 8'h0) core_pc <= seek(core_pc, 1'b0) + 16'd1;
                4'h7: begin
                    core_out   <= cur;
                    core_print <= 1'b1;
                    n_print    <= n_print + 1;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clock)
        if (tx_valid && tx_ready) rx.push_back(tx_data);

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input bit s, input bit l, input bit r);
        cyc();
        cmd_stop = s;
        cmd_load = l;
        cmd_run  = r;
        cyc();
        cmd_stop = 1'b0;
        cmd_load = 1'b0;
        cmd_run  = 1'b0;
    endtask

    task automatic load_prog(input bit fin);
        foreach (prog[i]) begin
            load_valid = 1'b1;
            load_nib   = prog[i];
            load_last  = fin && (i == prog.size() - 1);
            cyc();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_ce(input bit lvl, input int lim);
        int n = 0;
        while (core_ce != lvl && n < lim) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic wait_halt(input int lim);
        int n = 0;
        while (!halted && n < lim) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        int base;
        int np0;
        int nbad;
        logic [7:0] acc;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_outs", outs, 0);
        cyc();
        reset_n = 1'b1;

        // command priority in IDLE, stop inside LOAD
        cmd_stop = 1'b1; cmd_load = 1'b1; cmd_run = 1'b1;
        cyc();
        cmd_stop = 1'b0; cmd_load = 1'b0; cmd_run = 1'b0;
        @(negedge clock);
        chk("prio_all", {busy, load_ready}, 2'b00);
        cyc();
        cmd_load = 1'b1; cmd_run = 1'b1;
        cyc();
        cmd_load = 1'b0; cmd_run = 1'b0;
        @(negedge clock);
        chk("prio_load", {busy, load_ready}, 2'b11);
        cyc();
        load_valid = 1'b1; load_nib = 4'h7; cmd_stop = 1'b1;
        @(negedge clock);
        chk("stop_nib", {prg_we, load_ready}, 2'b00);
        cyc();
        load_valid = 1'b0; cmd_stop = 1'b0;
        @(negedge clock);
        chk("stop_idle", busy, 0);
        chk("stop_nowr", prg_ram[0], 4'h0);

        // "++." + end, clear sweep over pre-filled RAM
        tx_ready = 1'b1;
        base = rx.size();
        pulse(0, 1, 0);
        prog = '{4'h1, 4'h1, 4'h7, 4'hF};
        load_prog(1'b1);
        @(negedge clock);
        chk("b_load_idle", busy, 0);
        chk("b_prg", {prg_ram[0], prg_ram[1], prg_ram[2], prg_ram[3]},
            16'h117F);
        pulse(0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            chk($sformatf("clr%0d", i),
                {dat_we, dat_addr, dat_wdata, core_rst, core_ce},
                {1'b1, DAW'(i), 8'h00, 2'b00});
        end
        @(negedge clock);
        chk("rst_pulse", {core_rst, core_ce, dat_we, busy}, 4'b1001);
        @(negedge clock);
        chk("ce_first", {core_rst, core_ce}, 2'b01);
        wait_halt(40);
        chk("b_halt", {halted, busy}, 2'b10);
        chk("b_nrx", rx.size() - base, 1);
        chk("b_char", (rx.size() > base) ? rx[base] : 8'hFF, 8'h02);
        chk("b_cycles", run_cycles, 4);
        chk("b_dat0", dat_ram[0], 8'h02);
        acc = 8'h0;
        for (int i = 1; i < 16; i++) acc |= dat_ram[i];
        chk("b_dat_rest", acc, 8'h00);

        // "+[.]" against a blocked terminal, then stop and drain
        cyc();
        tx_ready = 1'b0;
        base = rx.size();
        np0 = n_print;
        pulse(0, 1, 0);
        prog = '{4'h1, 4'h5, 4'h7, 4'h6};
        load_prog(1'b1);
        pulse(0, 0, 1);
        wait_ce(1'b1, 30);
        chk("c_ce_on", core_ce, 1);
        wait_ce(1'b0, 80);
        chk("c_ce_off", core_ce, 0);
        repeat (3) @(negedge clock);
        chk("c_stall", {core_ce, busy, halted, tx_valid}, 4'b0101);
        chk("c_head", tx_data, 8'h01);
        chk("c_prints", n_print - np0, 7);
        chk("c_cycles", run_cycles, 16);
        cyc();
        tx_ready = 1'b1;
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        wait_halt(30);
        chk("c_halt", {halted, tx_valid}, 2'b10);
        chk("c_nrx", rx.size() - base, 7);
        nbad = 0;
        for (int i = base; i < rx.size(); i++)
            if (rx[i] != 8'h01) nbad++;
        chk("c_chars", nbad, 0);

        // reset while running with a filled FIFO, and while clearing
        cyc();
        tx_ready = 1'b0;
        pulse(0, 0, 1);
        wait_ce(1'b1, 30);
        repeat (10) @(negedge clock);
        chk("d_valid", {tx_valid, busy}, 2'b11);
        cyc();
        reset_n = 1'b0;
        @(negedge clock);
        chk("d_rst_run", outs, 0);
        cyc();
        reset_n = 1'b1;
        pulse(0, 0, 1);
        repeat (5) @(negedge clock);
        chk("d_clr", {dat_we, busy}, 2'b11);
        cyc();
        reset_n = 1'b0;
        @(negedge clock);
        chk("d_rst_clr", outs, 0);
        cyc();
        reset_n = 1'b1;

        // 17 nibbles into a 16-word program RAM
        pulse(0, 1, 0);
        prog.delete();
        for (int i = 0; i < 16; i++) prog.push_back(4'(i + 3));
        load_prog(1'b0);
        @(negedge clock);
        chk("e_still_load", {busy, load_ready}, 2'b11);
        cyc();
        load_valid = 1'b1; load_nib = 4'hE; load_last = 1'b1;
        @(negedge clock);
        chk("e_wrap_wr", {prg_we, prg_addr, prg_wdata}, 9'h10E);
        cyc();
        load_valid = 1'b0; load_last = 1'b0;
        @(negedge clock);
        chk("e_idle", {busy, load_ready}, 2'b00);
        chk("e_ram0", prg_ram[0], 4'hE);
        chk("e_ram1", prg_ram[1], 4'h4);
        chk("e_ram15", prg_ram[15], 4'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
